// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader
package prog_loader_pkg;

  localparam int CPU_INSTR_W    = 64;
  localparam int CPU_ADR_W      = 16;
  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FIN     = 2'd3
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host control, byte stream and instruction-memory write bus
interface prog_loader_if #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 64
);

  logic              start;
  logic              abort;
  logic [ADR_W-1:0]  base_adr;
  logic [ADR_W-1:0]  word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              cpu_hold;
  logic              done;

  modport master (
    output start, abort, base_adr, word_count, in_data, in_valid,
    input  in_ready, mem_adr, mem_wdata, mem_we, busy, cpu_hold, done
  );

  modport slave (
    input  start, abort, base_adr, word_count, in_data, in_valid,
    output in_ready, mem_adr, mem_wdata, mem_we, busy, cpu_hold, done
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// rtl/prog_loader_byte_packer.sv - packs accepted bytes LSB-first into one instruction word
module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = CPU_INSTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_complete
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  // The counter wraps to 0 after the last byte, so the next word starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt                      <= byte_cnt + 1'b1;
    end
  end

  assign word_complete = accept && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams bytes into instruction memory, one 64-bit word per write
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADR_W  = CPU_ADR_W,
  parameter int DATA_W = CPU_INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus
);

  state_t            state;
  state_t            next_state;
  logic [ADR_W-1:0]  base_q;
  logic [ADR_W-1:0]  count_q;
  logic [ADR_W-1:0]  idx_q;
  logic [DATA_W-1:0] word;
  logic              word_complete;
  logic              collecting;
  logic              accept;
  logic              start_take;
  logic              abort_hit;
  logic              write_fire;
  logic              last_word;

  logic              in_ready;
  logic              mem_we;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  // Abort drops ready in the same cycle so the source never sees a byte consumed.
  assign collecting = (state == COLLECT);
  assign in_ready   = collecting && !bus.abort;
  assign accept     = in_ready && bus.in_valid;
  assign start_take = (state == IDLE) && bus.start;
  assign abort_hit  = bus.abort && ((state == COLLECT) || (state == WRITE));
  assign write_fire = (state == WRITE) && !bus.abort;
  assign last_word  = ((idx_q + ADR_W'(1)) == count_q);

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_byte_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (start_take || abort_hit),
    .accept        (accept),
    .byte_in       (bus.in_data),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else if (start_take) begin
      base_q  <= bus.base_adr;
      count_q <= bus.word_count;
      idx_q   <= '0;
    end else if (write_fire) begin
      idx_q   <= idx_q + ADR_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_adr    = '0;
    mem_wdata  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          next_state = (bus.word_count != '0) ? COLLECT : FIN;
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (word_complete) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else begin
          mem_we     = 1'b1;
          mem_adr    = base_q + idx_q;
          mem_wdata  = word;
          next_state = last_word ? FIN : COLLECT;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_adr   = mem_adr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;
  assign bus.cpu_hold  = busy;
  assign bus.done      = done;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADR_W, default 16: width of the instruction-memory word address.
REQ-002 SHALL have parameter DATA_W, default 64: width of the instruction word; fixed at 8 bytes per word.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: cancels a load in progress.
REQ-007 SHALL have port base_adr  input  ADR_W: first word address to write; captured on accepted start.
REQ-008 SHALL have port word_count  input  ADR_W: number of words to load; captured on accepted start.
REQ-009 SHALL have port in_data  input  8: incoming program byte.
REQ-010 SHALL have port in_valid  input  1: in_data is valid.
REQ-011 SHALL have port in_ready  output  1: loader accepts a byte this cycle.
REQ-012 SHALL have port mem_adr  output  ADR_W: instruction-memory write address.
REQ-013 SHALL have port mem_wdata  output  DATA_W: instruction-memory write data.
REQ-014 SHALL have port mem_we  output  1: instruction-memory write enable.
REQ-015 SHALL have port busy  output  1: a load is in progress.
REQ-016 SHALL have port cpu_hold  output  1: stalls the processor's fetch path; identical to busy.
REQ-017 SHALL have port done  output  1: one-cycle pulse when the final word has been written.

Function
REQ-018 SHALL implement the FSM states IDLE, COLLECT, WRITE and FIN.
- IDLE: waits for start.
- COLLECT: gathers the 8 bytes of one word.
- WRITE: issues the memory write for that word.
- FIN: signals completion.
REQ-019 SHALL, in IDLE with start=1 and word_count!=0: capture base_adr and word_count, clear the word index and byte counter, and go to COLLECT.
REQ-020 SHALL, in IDLE with start=1 and word_count=0: go directly to FIN with no memory write.
REQ-021 SHALL drive in_ready=1 only in COLLECT; a byte is accepted on any cycle where in_valid and in_ready are both 1.
REQ-022 SHALL place accepted byte k (k=0..7 within a word) into bits [8k+7:8k]; byte 0 is the least significant.
REQ-023 SHALL leave the assembly register and byte counter unchanged on cycles with in_valid=0.
REQ-024 SHALL move to WRITE on the cycle after the 8th byte of a word is accepted.
REQ-025 SHALL, in WRITE, assert mem_we=1 for exactly one cycle.
- mem_adr = captured base + word index, modulo 2^ADR_W.
- mem_wdata = the assembled word.
REQ-026 SHALL, after WRITE: increment the word index, then go to FIN if the index reaches word_count, otherwise return to COLLECT.
REQ-027 SHALL assert done=1 for exactly one cycle in FIN and then return to IDLE.
REQ-028 SHALL drive busy=1 in COLLECT, WRITE and FIN, and busy=0 in IDLE.
REQ-029 SHALL ignore start while not in IDLE.
REQ-030 SHALL, on abort=1 in COLLECT or WRITE:
- go to IDLE on the next edge.
- suppress mem_we on that cycle.
- discard any partially assembled word.
- not assert done.
- abort takes priority over a simultaneous byte accept or write.
REQ-031 SHALL let the write address wrap from 2^ADR_W-1 to 0 without error.
REQ-032 SHALL drive mem_adr and mem_wdata to 0 whenever mem_we=0.

Reset
REQ-033 SHALL, while rst_n=0 and immediately on its assertion:
- force state to IDLE.
- set in_ready, mem_we, busy, cpu_hold and done to 0.
- set mem_adr, mem_wdata, the word index, the byte counter and the assembly register to 0.
REQ-034 SHALL, if reset is asserted mid-load, never complete the partial word or the rest of the load.

Structure
REQ-035 SHALL take the FSM state encoding and the BYTES_PER_WORD=8 constant from a shared package, alongside the processor's instruction-width and address-width constants.
REQ-036 SHALL contain one natural sub-module, byte_packer, which holds the byte counter and assembly register and raises a word-complete indication.

Verification
REQ-037 Bench SHALL cover a single-word load:
- stimulus: base_adr=0x0010, word_count=1, bytes 0x01..0x08 streamed back-to-back.
- required: one mem_we at mem_adr=0x0010 with mem_wdata=0x0807060504030201, then done one cycle later, then busy=0.
REQ-038 Bench SHALL cover a gapped multi-word load:
- stimulus: base_adr=0x0100, word_count=3, in_valid toggling every other cycle.
- required: writes to 0x0100, 0x0101 and 0x0102 in order with correct words; exactly one done pulse.
REQ-039 Bench SHALL cover address wrap:
- stimulus: base_adr=0xFFFF, word_count=2.
- required: writes at 0xFFFF and then 0x0000.
REQ-040 Bench SHALL cover zero count:
- stimulus: start with word_count=0.
- required: no mem_we; done high on the second cycle after start.
REQ-041 Bench SHALL cover abort:
- stimulus: abort after 5 bytes of word 2 of 4.
- required: only word 1 written; no done; IDLE next cycle.
- follow-up: a new start is then accepted normally.
REQ-042 Bench SHALL cover reset and start during a load:
- stimulus: rst_n pulled low mid-COLLECT.
- required: all outputs 0 immediately, with no clock edge needed.
- stimulus: start asserted during a load.
- required: captured base and count unchanged.
